// File: rtl/ex_pkg.sv
// ex_pkg: shared ALU function codes, bypass selector, and skid-entry layout for the execute stage.
// Rev 1.0
`default_nettype none
package ex_pkg;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;

  localparam int EX_WIDTH = 32;
  localparam int EX_RAW   = 5;

  typedef enum logic [1:0] {
    FWD_NONE = 2'd0,
    FWD_LAST = 2'd1,
    FWD_WB   = 2'd2
  } fwd_sel_e;

  // Field order matches the packed vector carried through the skid buffer.
  typedef struct packed {
    logic [EX_WIDTH-1:0] y;
    logic                z;
    logic [EX_RAW-1:0]   rd;
    logic                we;
  } skid_entry_t;

endpackage
`default_nettype wire

// File: rtl/ex_alu.sv
// ex_alu: combinational team ALU (add/sub/and/or/xor, other codes yield 0) with zero flag.
// Rev 1.0
`default_nettype none
module ex_alu
  import ex_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       i_f,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_y,
  output logic             o_z
);

  always_comb begin
    o_y = '0;
    case (i_f)
      ALU_ADD: o_y = i_a + i_b;
      ALU_SUB: o_y = i_a - i_b;
      ALU_AND: o_y = i_a & i_b;
      ALU_OR:  o_y = i_a | i_b;
      ALU_XOR: o_y = i_a ^ i_b;
      default: o_y = '0;
    endcase
  end

  assign o_z = (o_y == '0);

endmodule
`default_nettype wire

// File: rtl/ex_skid_buf.sv
// ex_skid_buf: 2-entry FIFO with registered ready; entry 0 is always the head.
// Rev 1.0
`default_nettype none
module ex_skid_buf #(
  parameter int             DW      = 8,
  parameter logic [DW-1:0]  RST_VAL = '0
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          i_flush,
  input  logic          i_push,
  input  logic [DW-1:0] i_data,
  input  logic          i_pop,
  output logic          o_valid,
  output logic [DW-1:0] o_data,
  output logic          o_ready
);

  logic [1:0]    r_cnt;
  logic [1:0]    w_cnt_nxt;
  logic [DW-1:0] r_mem0;
  logic [DW-1:0] r_mem1;
  logic          r_rdy;
  logic          w_push;
  logic          w_pop;

  assign w_push  = i_push && r_rdy;
  assign w_pop   = i_pop && (r_cnt != 2'd0);
  assign o_valid = (r_cnt != 2'd0);
  assign o_data  = r_mem0;
  assign o_ready = r_rdy;

  always_comb begin
    w_cnt_nxt = r_cnt;
    case ({w_push, w_pop})
      2'b10:   w_cnt_nxt = r_cnt + 2'd1;
      2'b01:   w_cnt_nxt = r_cnt - 2'd1;
      default: w_cnt_nxt = r_cnt;
    endcase
    if (i_flush) w_cnt_nxt = 2'd0;
  end

  // A push can only land when occupancy < 2, so push+pop never meets a full buffer.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt  <= 2'd0;
      r_rdy  <= 1'b1;
      r_mem0 <= RST_VAL;
      r_mem1 <= RST_VAL;
    end else begin
      r_cnt <= w_cnt_nxt;
      r_rdy <= (w_cnt_nxt != 2'd2);
      if (!i_flush) begin
        if (w_pop)
          r_mem0 <= (w_push && (r_cnt == 2'd1)) ? i_data : r_mem1;
        else if (w_push && (r_cnt == 2'd0))
          r_mem0 <= i_data;
        if (w_push && !w_pop && (r_cnt == 2'd1))
          r_mem1 <= i_data;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/ex_stage.sv
// ex_stage: execute stage with operand bypass (EX_FORWARD_EN), ALU and 2-entry output skid buffer.
// Rev 1.0
`default_nettype none
module ex_stage
  import ex_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int RAW   = 5
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_f,
  input  logic [RAW-1:0]   in_rs1,
  input  logic [RAW-1:0]   in_rs2,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [RAW-1:0]   in_rd,
  input  logic             in_we,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
  output logic             out_z,
  output logic [RAW-1:0]   out_rd,
  output logic             out_we,
  input  logic             wb_we,
  input  logic [RAW-1:0]   wb_rd,
  input  logic [WIDTH-1:0] wb_data
);

  localparam int DW = WIDTH + RAW + 2;
  localparam logic [DW-1:0] c_ENTRY_RST = {{WIDTH{1'b0}}, 1'b1, {RAW{1'b0}}, 1'b0};

  logic             w_acc;
  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;
  logic [WIDTH-1:0] w_y;
  logic             w_z;
  logic [DW-1:0]    w_head;

  assign w_acc = in_valid && in_ready;

`ifdef EX_FORWARD_EN
  logic [WIDTH-1:0] r_last_y;
  logic [RAW-1:0]   r_last_rd;
  logic             r_last_we;
  fwd_sel_e         w_sel_a;
  fwd_sel_e         w_sel_b;

  // Newest accepted result wins over the write-back bus; index 0 never bypasses.
  always_comb begin
    w_sel_a = FWD_NONE;
    if (r_last_we && (r_last_rd != '0) && (r_last_rd == in_rs1)) w_sel_a = FWD_LAST;
    else if (wb_we && (wb_rd != '0) && (wb_rd == in_rs1))        w_sel_a = FWD_WB;
    w_sel_b = FWD_NONE;
    if (r_last_we && (r_last_rd != '0) && (r_last_rd == in_rs2)) w_sel_b = FWD_LAST;
    else if (wb_we && (wb_rd != '0) && (wb_rd == in_rs2))        w_sel_b = FWD_WB;
  end

  always_comb begin
    w_a = in_a;
    w_b = in_b;
    case (w_sel_a)
      FWD_LAST: w_a = r_last_y;
      FWD_WB:   w_a = wb_data;
      default:  w_a = in_a;
    endcase
    case (w_sel_b)
      FWD_LAST: w_b = r_last_y;
      FWD_WB:   w_b = wb_data;
      default:  w_b = in_b;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_last_y  <= '0;
      r_last_rd <= '0;
      r_last_we <= 1'b0;
    end else if (flush) begin
      r_last_we <= 1'b0;
    end else if (w_acc) begin
      r_last_y  <= w_y;
      r_last_rd <= in_rd;
      r_last_we <= in_we;
    end
  end
`else
  logic w_unused;
  assign w_unused = ^{in_rs1, in_rs2, wb_we, wb_rd, wb_data};
  assign w_a = in_a;
  assign w_b = in_b;
`endif

  ex_alu #(.WIDTH(WIDTH)) u_alu (
    .i_f (in_f),
    .i_a (w_a),
    .i_b (w_b),
    .o_y (w_y),
    .o_z (w_z)
  );

  ex_skid_buf #(.DW(DW), .RST_VAL(c_ENTRY_RST)) u_skid (
    .clk     (clk),
    .rstn    (rstn),
    .i_flush (flush),
    .i_push  (in_valid),
    .i_data  ({w_y, w_z, in_rd, in_we}),
    .i_pop   (out_ready),
    .o_valid (out_valid),
    .o_data  (w_head),
    .o_ready (in_ready)
  );

  assign {out_y, out_z, out_rd, out_we} = w_head;

endmodule
`default_nettype wire

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed self-checking bench for ex_stage; forwarding expectations follow EX_FORWARD_EN.
// Rev 1.0
`default_nettype none
module tb_ex_stage;

  logic        clk = 1'b0;
  logic        rstn;
  logic        in_valid, in_ready, in_we, flush, out_valid, out_ready, out_z, out_we, wb_we;
  logic [2:0]  in_f;
  logic [4:0]  in_rs1, in_rs2, in_rd, out_rd, wb_rd;
  logic [31:0] in_a, in_b, out_y, wb_data;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  ex_stage #(.WIDTH(32), .RAW(5)) dut (
    .clk(clk), .rstn(rstn),
    .in_valid(in_valid), .in_ready(in_ready), .in_f(in_f),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_a(in_a), .in_b(in_b),
    .in_rd(in_rd), .in_we(in_we), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y), .out_z(out_z),
    .out_rd(out_rd), .out_we(out_we),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Present one op for one clock edge, then sample 1ns after that edge.
  task automatic op(input logic [2:0] f, input logic [4:0] rs1, input logic [31:0] a,
                    input logic [4:0] rs2, input logic [31:0] b,
                    input logic [4:0] rd, input logic we);
    in_valid = 1'b1; in_f = f; in_rs1 = rs1; in_a = a; in_rs2 = rs2; in_b = b;
    in_rd = rd; in_we = we;
    @(posedge clk); #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic op_chk(input string tag, input logic [2:0] f, input logic [4:0] rs1,
                        input logic [31:0] a, input logic [4:0] rs2, input logic [31:0] b,
                        input logic [4:0] rd, input logic [31:0] exp_y);
    op(f, rs1, a, rs2, b, rd, 1'b1);
    check({tag, ".valid"}, 64'(out_valid), 64'd1);
    check({tag, ".y"},     64'(out_y),     64'(exp_y));
    check({tag, ".z"},     64'(out_z),     64'(exp_y == 32'd0));
    check({tag, ".rd"},    64'(out_rd),    64'(rd));
  endtask

`ifdef EX_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  initial begin
    rstn = 1'b0; in_valid = 1'b0; in_f = '0; in_rs1 = '0; in_rs2 = '0; in_a = '0; in_b = '0;
    in_rd = '0; in_we = 1'b0; flush = 1'b0; out_ready = 1'b1;
    wb_we = 1'b0; wb_rd = '0; wb_data = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.valid", 64'(out_valid), 64'd0);
    check("rst.y",     64'(out_y),     64'd0);
    check("rst.z",     64'(out_z),     64'd1);
    check("rst.rd",    64'(out_rd),    64'd0);
    check("rst.we",    64'(out_we),    64'd0);
    check("rst.ready", 64'(in_ready),  64'd1);
    @(negedge clk); rstn = 1'b1;
    @(posedge clk); #1;

    op_chk("add", 3'b000, 5'd1, 32'd5, 5'd2, 32'd7, 5'd3, 32'd12);
    check("add.we", 64'(out_we), 64'd1);
    op(3'b001, 5'd1, 32'd9, 5'd2, 32'd9, 5'd7, 1'b0);
    check("sub0.y",  64'(out_y),  64'd0);
    check("sub0.z",  64'(out_z),  64'd1);
    check("sub0.we", 64'(out_we), 64'd0);
    op_chk("f111", 3'b111, 5'd1, 32'd3, 5'd2, 32'd4, 5'd8, 32'd0);
    op_chk("and",  3'b010, 5'd1, 32'h0000_F0F0, 5'd2, 32'h0000_FF00, 5'd9, 32'h0000_F000);
    op_chk("xor",  3'b100, 5'd1, 32'hFF, 5'd2, 32'h0F, 5'd10, 32'hF0);
    op_chk("subw", 3'b001, 5'd1, 32'd0, 5'd2, 32'd1, 5'd11, 32'hFFFF_FFFF);
    op_chk("addw", 3'b000, 5'd1, 32'hFFFF_FFFF, 5'd2, 32'd1, 5'd12, 32'd0);

    // Back-to-back dependency through the last-result register.
    op_chk("dep1", 3'b000, 5'd1, 32'd4, 5'd2, 32'd6, 5'd4, 32'd10);
    op_chk("dep2", 3'b000, 5'd4, 32'd0, 5'd2, 32'd1, 5'd13, FWD ? 32'd11 : 32'd1);
    op_chk("r0a",  3'b000, 5'd1, 32'd10, 5'd2, 32'd0, 5'd0, 32'd10);
    op_chk("r0b",  3'b000, 5'd0, 32'd0, 5'd2, 32'd1, 5'd14, 32'd1);

    // Write-back bypass, then last-result precedence over it.
    wb_we = 1'b1; wb_rd = 5'd6; wb_data = 32'hFF;
    op_chk("wb",   3'b011, 5'd1, 32'd0, 5'd6, 32'd0, 5'd15, FWD ? 32'hFF : 32'd0);
    op_chk("wbp",  3'b000, 5'd1, 32'h11, 5'd2, 32'd0, 5'd6, 32'h11);
    op_chk("prio", 3'b011, 5'd1, 32'd0, 5'd6, 32'd0, 5'd16, FWD ? 32'h11 : 32'd0);
    wb_we = 1'b0;
    idle();
    check("drain.valid", 64'(out_valid), 64'd0);

    // Back-pressure: two accepted, third held off until a pop frees a slot.
    out_ready = 1'b0;
    op(3'b000, 5'd1, 32'd1, 5'd2, 32'd1, 5'd17, 1'b1);
    check("bp1.ready", 64'(in_ready), 64'd1);
    op(3'b000, 5'd1, 32'd2, 5'd2, 32'd1, 5'd18, 1'b1);
    check("bp2.ready", 64'(in_ready), 64'd0);
    check("bp2.y",     64'(out_y),    64'd2);
    op(3'b000, 5'd1, 32'd100, 5'd2, 32'd0, 5'd19, 1'b1);
    check("bp3.ready", 64'(in_ready), 64'd0);
    check("bp3.valid", 64'(out_valid), 64'd1);
    check("bp3.y",     64'(out_y),    64'd2);
    check("bp3.rd",    64'(out_rd),   64'd17);
    out_ready = 1'b1;
    idle();
    check("pop1.y",     64'(out_y),     64'd3);
    check("pop1.rd",    64'(out_rd),    64'd18);
    check("pop1.ready", 64'(in_ready),  64'd1);
    idle();
    check("pop2.valid", 64'(out_valid), 64'd0);

    // Flush with two entries buffered and in_valid high.
    out_ready = 1'b0;
    op(3'b000, 5'd1, 32'd50, 5'd2, 32'd0, 5'd20, 1'b1);
    op(3'b000, 5'd1, 32'd60, 5'd2, 32'd0, 5'd21, 1'b1);
    flush = 1'b1;
    op(3'b000, 5'd1, 32'd70, 5'd2, 32'd0, 5'd22, 1'b1);
    flush = 1'b0;
    check("fl1.valid", 64'(out_valid), 64'd0);
    check("fl1.ready", 64'(in_ready),  64'd1);
    out_ready = 1'b1;
    idle();
    idle();
    check("fl1.after", 64'(out_valid), 64'd0);

    // Flush with one entry and a simultaneous accept; last-result must also be cleared.
    out_ready = 1'b0;
    op(3'b000, 5'd1, 32'd50, 5'd2, 32'd0, 5'd12, 1'b1);
    flush = 1'b1;
    op(3'b000, 5'd1, 32'd7, 5'd2, 32'd0, 5'd22, 1'b1);
    flush = 1'b0;
    check("fl2.valid", 64'(out_valid), 64'd0);
    idle();
    check("fl2.after", 64'(out_valid), 64'd0);
    out_ready = 1'b1;
    op_chk("fl2.nofwd", 3'b000, 5'd12, 32'd1, 5'd2, 32'd1, 5'd23, 32'd2);

    // Asynchronous reset mid-stream.
    out_ready = 1'b0;
    op(3'b000, 5'd1, 32'd77, 5'd2, 32'd0, 5'd13, 1'b1);
    check("pre.valid", 64'(out_valid), 64'd1);
    in_valid = 1'b0;
    #3 rstn = 1'b0;
    #1;
    check("arst.valid", 64'(out_valid), 64'd0);
    check("arst.y",     64'(out_y),     64'd0);
    check("arst.z",     64'(out_z),     64'd1);
    check("arst.rd",    64'(out_rd),    64'd0);
    check("arst.we",    64'(out_we),    64'd0);
    check("arst.ready", 64'(in_ready),  64'd1);
    #2 rstn = 1'b1;
    idle();
    check("post.valid", 64'(out_valid), 64'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
